// File: rtl/sync_fifo_arb_ctrl.sv
// Round-robin write arbiter and valid/ready read adapter for a shared SYNC_FIFO.
// Read side hides the FIFO's one-cycle pop latency behind a 2-entry skid buffer.
module sync_fifo_arb_ctrl #(
   parameter int REQ_NUM     = 4,
   parameter int REQ_NUM_W   = 2,
   parameter int DAT_W       = 32,
   parameter int FIFO_DEEP_W = 3
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [REQ_NUM-1:0]           req_vld,
   input  logic [REQ_NUM*DAT_W-1:0]     req_dat,
   output logic [REQ_NUM-1:0]           req_rdy,
   output logic                         fifo_push,
   output logic [DAT_W+REQ_NUM_W-1:0]   fifo_push_dat,
   input  logic                         fifo_full,
   input  logic                         fifo_empty,
   output logic                         fifo_pop,
   input  logic [DAT_W+REQ_NUM_W-1:0]   fifo_pop_dat,
   input  logic                         fifo_pop_dat_vld,
   output logic                         out_vld,
   output logic [DAT_W-1:0]             out_dat,
   output logic [REQ_NUM_W-1:0]         out_src,
   input  logic                         out_rdy,
   output logic [1:0]                   skid_cnt
);

   localparam int W = DAT_W + REQ_NUM_W;

   logic [DAT_W-1:0]     req_arr [REQ_NUM];
   logic [REQ_NUM_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [REQ_NUM_W-1:0] cand;
   logic [REQ_NUM_W-1:0] gnt_idx;
   logic                 gnt_vld;
   logic                 inflight_q;
   logic                 drain;
   logic [2:0]           occ;
   logic [W-1:0]         skid_q [2];
   logic                 rd_q, wr_q;
   logic [1:0]           cnt_q, cnt_d;

   for (genvar i = 0; i < REQ_NUM; i++) begin : g_unpack
      assign req_arr[i] = req_dat[i*DAT_W +: DAT_W];
   end

   // First requester at or after rr_ptr, wrapping to 0.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      for (int k = 0; k < REQ_NUM; k++) begin
         cand = REQ_NUM_W'((int'(rr_ptr_q) + k) % REQ_NUM);
         if (!gnt_vld && req_vld[cand]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand;
         end
      end
      if (fifo_full) gnt_vld = 1'b0;
   end

   assign fifo_push     = gnt_vld;
   assign req_rdy       = gnt_vld ? (REQ_NUM'(1) << gnt_idx) : '0;
   assign fifo_push_dat = {gnt_idx, req_arr[gnt_idx]};

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (fifo_push) begin
         if (gnt_idx == REQ_NUM_W'(REQ_NUM - 1)) rr_ptr_d = '0;
         else rr_ptr_d = gnt_idx + 1'b1;
      end
   end

   // Pop only if the skid can absorb the word already in flight plus this one.
   assign drain    = out_vld & out_rdy;
   assign occ      = {1'b0, cnt_q} + {2'b0, inflight_q} - {2'b0, drain};
   assign fifo_pop = ~fifo_empty & (occ < 3'd2);

   assign cnt_d    = cnt_q + {1'b0, fifo_pop_dat_vld} - {1'b0, drain};
   assign out_vld  = (cnt_q != 2'd0);
   assign {out_src, out_dat} = skid_q[rd_q];
   assign skid_cnt = cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q   <= '0;
         inflight_q <= 1'b0;
         cnt_q      <= 2'd0;
         rd_q       <= 1'b0;
         wr_q       <= 1'b0;
         skid_q[0]  <= '0;
         skid_q[1]  <= '0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         inflight_q <= fifo_pop;
         cnt_q      <= cnt_d;
         if (fifo_pop_dat_vld) begin
            skid_q[wr_q] <= fifo_pop_dat;
            wr_q         <= ~wr_q;
         end
         if (drain) rd_q <= ~rd_q;
      end
   end

   a_params : assert property (@(posedge clk)
      (FIFO_DEEP_W >= 1) && ((1 << REQ_NUM_W) >= REQ_NUM));

   a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
      !(fifo_pop_dat_vld && (cnt_q == 2'd2) && !drain));

   a_inflight : assert property (@(posedge clk) disable iff (!rst_n)
      fifo_pop_dat_vld == inflight_q);

endmodule
